riscv_muldiv: RTL

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in word length. It sits in the execute stage beside `riscv_alu`. The pipeline launches an operation with `start`, stalls while `busy` is high, and consumes `result` in the cycle `valid` pulses. Multiplication and division share one radix-2 shift/add-subtract datapath.

---
 rtl/riscv_constants.sv | 22 ++
 rtl/riscv_muldiv.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/riscv_constants.sv
// Shared RISC-V constants: multiply/divide function codes (funct3 encoding)
// and the multiply/divide unit state encoding.
package riscv_constants;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } MDU_FUN;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift/add-subtract step per
// cycle on unsigned magnitudes, with sign fix-up on the final step.
module riscv_muldiv
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   flush,
  input  MDU_FUN                 mdu_fun,
  input  logic [WORD_LENGTH-1:0] data1,
  input  logic [WORD_LENGTH-1:0] data2,
  output logic                   busy,
  output logic                   valid,
  output logic [WORD_LENGTH-1:0] result
);

  localparam int W = WORD_LENGTH;
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] neg_word(input logic neg, input logic [W-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg_dword(input logic neg, input logic [2*W-1:0] v);
    return neg ? -v : v;
  endfunction

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  MDU_FUN           fun_q;
  logic             neg_q;
  logic [W-1:0]     opnd_q, acc_hi_q, acc_lo_q;
  logic [W-1:0]     result_q;

  // Acceptance-cycle decode: sign stripping and fast-path detection
  logic         accept, in_div, sgn1, sgn2, in_neg1, in_neg2, in_neg;
  logic         div_zero, div_ovf, fast;
  logic [W-1:0] mag1, mag2, fast_result;

  assign accept   = start & ~flush & (state_q != MDU_CALC);
  assign in_div   = mdu_fun[2];
  assign sgn1     = (mdu_fun == MDU_MULH) | (mdu_fun == MDU_MULHSU) | (in_div & ~mdu_fun[0]);
  assign sgn2     = (mdu_fun == MDU_MULH) | (in_div & ~mdu_fun[0]);
  assign in_neg1  = sgn1 & data1[W-1];
  assign in_neg2  = sgn2 & data2[W-1];
  assign mag1     = neg_word(in_neg1, data1);
  assign mag2     = neg_word(in_neg2, data2);
  // Remainders follow the dividend; quotients and products follow the sign product
  assign in_neg   = (in_div & mdu_fun[1]) ? in_neg1 : (in_neg1 ^ in_neg2);
  assign div_zero = in_div & (data2 == '0);
  assign div_ovf  = in_div & ~mdu_fun[0] & (data1 == MOST_NEG) & (&data2);
  assign fast     = div_zero | div_ovf;
  assign fast_result = div_zero ? (mdu_fun[1] ? data1 : '1)
                                : (mdu_fun[1] ? '0 : data1);

  // Shared adder/subtractor and one iteration step
  logic         is_div;
  logic [W:0]   add_a, add_b, addsub;
  logic [W-1:0] step_hi, step_lo;
  logic [2*W-1:0] prod;
  logic [W-1:0] calc_result;

  assign is_div = fun_q[2];
  assign add_a  = is_div ? {acc_hi_q, acc_lo_q[W-1]} : {1'b0, acc_hi_q};
  assign add_b  = {1'b0, opnd_q};
  assign addsub = is_div ? (add_a - add_b) : (add_a + add_b);

  always_comb begin
    step_hi = {1'b0, acc_hi_q[W-1:1]};
    step_lo = {acc_hi_q[0], acc_lo_q[W-1:1]};
    if (is_div) begin
      step_hi = addsub[W] ? {acc_hi_q[W-2:0], acc_lo_q[W-1]} : addsub[W-1:0];
      step_lo = {acc_lo_q[W-2:0], ~addsub[W]};
    end else if (acc_lo_q[0]) begin
      step_hi = addsub[W:1];
      step_lo = {addsub[0], acc_lo_q[W-1:1]};
    end
  end

  assign prod = neg_dword(neg_q, {step_hi, step_lo});

  always_comb begin
    calc_result = prod[W-1:0];
    case (fun_q)
      MDU_MUL:                        calc_result = prod[W-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: calc_result = prod[2*W-1:W];
      MDU_DIV, MDU_DIVU:              calc_result = neg_word(neg_q, step_lo);
      MDU_REM, MDU_REMU:              calc_result = neg_word(neg_q, step_hi);
      default:                        calc_result = prod[W-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q == MDU_CALC);
    valid   = (state_q == MDU_DONE);
    case (state_q)
      MDU_IDLE, MDU_DONE: begin
        if (accept) state_d = fast ? MDU_DONE : MDU_CALC;
        else        state_d = MDU_IDLE;
      end
      MDU_CALC: if (cnt_q == CNT_LAST) state_d = MDU_DONE;
      default:  state_d = MDU_IDLE;
    endcase
    if (flush) state_d = MDU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept)                   cnt_q <= '0;
      else if (state_q == MDU_CALC) cnt_q <= cnt_q + CNT_W'(1);
      if (!flush) begin
        if (accept && fast)
          result_q <= fast_result;
        else if (state_q == MDU_CALC && cnt_q == CNT_LAST)
          result_q <= calc_result;
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      fun_q    <= mdu_fun;
      neg_q    <= in_neg;
      opnd_q   <= in_div ? mag2 : mag1;
      acc_hi_q <= '0;
      acc_lo_q <= in_div ? mag1 : mag2;
    end else if (state_q == MDU_CALC) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
    end
  end

  assign result = result_q;

endmodule
